// File: rtl/parity_check_pkg.sv
// Shared constants and types for the parity checker slice.
package parity_check_pkg;
  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_CNT_W = 16;

  localparam bit EVEN_PARITY = 1'b0;
  localparam bit ODD_PARITY  = 1'b1;

  typedef logic [DEF_CNT_W-1:0] err_cnt_t;
endpackage

// File: rtl/parity_check_tree.sv
// parity_tree: combinational XOR reduction of a WIDTH-bit word.
module parity_tree
  import parity_check_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] s,
  output logic             p
);
  logic [WIDTH-1:0] acc;

  assign acc[0] = s[0];
  for (genvar i = 1; i < WIDTH; i++) begin : g_xor
    assign acc[i] = acc[i-1] ^ s[i];
  end

  assign p = acc[WIDTH-1];
endmodule

// File: rtl/parity_check.sv
// Registered parity checker; error statistics exist only when
// PARITY_CHECK_STATS_EN is defined.
module parity_check
  import parity_check_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter bit          ODD   = EVEN_PARITY
`ifdef PARITY_CHECK_STATS_EN
  , parameter int unsigned CNT_W = DEF_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s,
  input  logic             in_valid,
`ifdef PARITY_CHECK_STATS_EN
  input  logic             clr_stats,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky,
`endif
  output logic             check,
  output logic             out_valid
);
  logic p, r;

  parity_tree #(.WIDTH(WIDTH)) u_tree (.s(s), .p(p));

  assign r = p ^ ODD;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      check     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) check <= r;
    end
  end

`ifdef PARITY_CHECK_STATS_EN
  // Counts the result being registered this cycle, so it tracks check as it rises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (clr_stats) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (in_valid && r) begin
      err_sticky <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_parity_check.sv
// Randomized bench for parity_check: four instances against a behavioural model.
module tb_parity_check;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] sw;
  logic        iv;
  logic        clr;
  logic        armed = 1'b0;
  int          checks = 0;
  int          failures = 0;

  logic chk_a, chk_b, chk_c, chk_d;
  logic ov_a, ov_b, ov_c, ov_d;
`ifdef PARITY_CHECK_STATS_EN
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;
  logic [2:0]  cnt_d;
  logic        st_a, st_b, st_c, st_d;
`endif

  always #5 clk = ~clk;

  parity_check #(.WIDTH(4), .ODD(1'b0)
`ifdef PARITY_CHECK_STATS_EN
    , .CNT_W(16)
`endif
  ) dut_a (.clk(clk), .rst_n(rst_n), .s(sw[3:0]), .in_valid(iv),
`ifdef PARITY_CHECK_STATS_EN
    .clr_stats(clr), .err_cnt(cnt_a), .err_sticky(st_a),
`endif
    .check(chk_a), .out_valid(ov_a));

  parity_check #(.WIDTH(4), .ODD(1'b1)
`ifdef PARITY_CHECK_STATS_EN
    , .CNT_W(16)
`endif
  ) dut_b (.clk(clk), .rst_n(rst_n), .s(sw[3:0]), .in_valid(iv),
`ifdef PARITY_CHECK_STATS_EN
    .clr_stats(clr), .err_cnt(cnt_b), .err_sticky(st_b),
`endif
    .check(chk_b), .out_valid(ov_b));

  parity_check #(.WIDTH(4), .ODD(1'b0)
`ifdef PARITY_CHECK_STATS_EN
    , .CNT_W(2)
`endif
  ) dut_c (.clk(clk), .rst_n(rst_n), .s(sw[3:0]), .in_valid(iv),
`ifdef PARITY_CHECK_STATS_EN
    .clr_stats(clr), .err_cnt(cnt_c), .err_sticky(st_c),
`endif
    .check(chk_c), .out_valid(ov_c));

  parity_check #(.WIDTH(13), .ODD(1'b1)
`ifdef PARITY_CHECK_STATS_EN
    , .CNT_W(3)
`endif
  ) dut_d (.clk(clk), .rst_n(rst_n), .s(sw), .in_valid(iv),
`ifdef PARITY_CHECK_STATS_EN
    .clr_stats(clr), .err_cnt(cnt_d), .err_sticky(st_d),
`endif
    .check(chk_d), .out_valid(ov_d));

  logic act_chk [4];
  logic act_ov  [4];
  assign act_chk[0] = chk_a; assign act_chk[1] = chk_b;
  assign act_chk[2] = chk_c; assign act_chk[3] = chk_d;
  assign act_ov[0]  = ov_a;  assign act_ov[1]  = ov_b;
  assign act_ov[2]  = ov_c;  assign act_ov[3]  = ov_d;
`ifdef PARITY_CHECK_STATS_EN
  int   act_cnt [4];
  logic act_st  [4];
  assign act_cnt[0] = int'(cnt_a); assign act_cnt[1] = int'(cnt_b);
  assign act_cnt[2] = int'(cnt_c); assign act_cnt[3] = int'(cnt_d);
  assign act_st[0]  = st_a; assign act_st[1] = st_b;
  assign act_st[2]  = st_c; assign act_st[3] = st_d;
`endif

  // Model: parity is the ones-count mod 2, flipped for odd sense.
  function automatic logic model_par(input int k, input logic [12:0] w);
    int n;
    n = (k < 3) ? $countones(w[3:0]) : $countones(w);
    return ((n % 2) == 1) ^ (k == 1 || k == 3);
  endfunction

  function automatic int cnt_max(input int k);
    case (k)
      2:       return 3;
      3:       return 7;
      default: return 65535;
    endcase
  endfunction

  logic exp_chk [4];
  logic exp_ov  [4];
  int   exp_cnt [4];
  logic exp_st  [4];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        exp_chk[k] <= 1'b0;
        exp_ov[k]  <= 1'b0;
        exp_cnt[k] <= 0;
        exp_st[k]  <= 1'b0;
      end else begin
        exp_ov[k] <= iv;
        if (iv) exp_chk[k] <= model_par(k, sw);
        if (clr) begin
          exp_cnt[k] <= 0;
          exp_st[k]  <= 1'b0;
        end else if (iv && model_par(k, sw)) begin
          exp_st[k] <= 1'b1;
          if (exp_cnt[k] < cnt_max(k)) exp_cnt[k] <= exp_cnt[k] + 1;
        end
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 4; k++) begin
        cmp($sformatf("d%0d.check", k), int'(act_chk[k]), int'(exp_chk[k]));
        cmp($sformatf("d%0d.out_valid", k), int'(act_ov[k]), int'(exp_ov[k]));
`ifdef PARITY_CHECK_STATS_EN
        cmp($sformatf("d%0d.err_cnt", k), act_cnt[k], exp_cnt[k]);
        cmp($sformatf("d%0d.err_sticky", k), int'(act_st[k]), int'(exp_st[k]));
`endif
      end
    end
  end

  // Inputs change at the negedge; results are visible at the following negedge.
  task automatic drive(input logic [12:0] w, input logic v, input logic c);
    sw = w; iv = v; clr = c;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] tbl;
    tbl = 16'h6996;
    rst_n = 1'b0; sw = 13'h000F; iv = 1'b1; clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    armed = 1'b1;
    cmp("rst.check", int'(chk_a), 0);
    cmp("rst.out_valid", int'(ov_a), 0);
`ifdef PARITY_CHECK_STATS_EN
    cmp("rst.err_cnt", int'(cnt_a), 0);
`endif

    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(13'(i), 1'b1, 1'b0);
      cmp($sformatf("sweep%0d.check", i), int'(chk_a), int'(tbl[i]));
      cmp($sformatf("sweep%0d.out_valid", i), int'(ov_a), 1);
    end
`ifdef PARITY_CHECK_STATS_EN
    cmp("sweep.err_cnt", int'(cnt_a), 8);
    cmp("sweep.err_sticky", int'(st_a), 1);
    cmp("sweep.sat_cnt", int'(cnt_c), 3);
    drive(13'h1, 1'b1, 1'b1);
    cmp("clr.err_cnt", int'(cnt_a), 0);
    cmp("clr.err_sticky", int'(st_a), 0);
    cmp("clr.check", int'(chk_a), 1);
`endif

    drive(13'h1, 1'b1, 1'b0);
    cmp("hold0.check", int'(chk_a), 1);
    drive(13'h0, 1'b0, 1'b0);
    cmp("hold1.check", int'(chk_a), 1);
    cmp("hold1.out_valid", int'(ov_a), 0);

    drive(13'h5, 1'b1, 1'b0);
    cmp("odd.0101", int'(chk_b), 1);
    drive(13'h4, 1'b1, 1'b0);
    cmp("odd.0100", int'(chk_b), 0);

`ifdef PARITY_CHECK_STATS_EN
    drive(13'h0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      drive(13'h1, 1'b1, 1'b0);
      cmp($sformatf("sat%0d.err_cnt", k), int'(cnt_c), (k < 3) ? k : 3);
    end
`endif

    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive(13'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    end

    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/parity_check.md
# parity_check

Registered parity checker for a narrow data word. Computes the XOR reduction of the input word `s` and presents it as `check`, one clock after the word is sampled. An optional statistics block counts and flags parity errors. Sits at the receive side of any link carrying a parity-protected nibble.

## Interface
- `WIDTH`, 4: width of `s` in bits; legal range 2..32.
- `ODD`, 0: parity sense. With 0, `check` is 1 when `s` has an odd number of ones; with 1, `check` is inverted.
- `CNT_W`, 16: width of the error counter, present only with stats.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `s`  in  WIDTH  data word under check.
- `in_valid`  in  1  `s` is sampled when this is high.
- `check`  out  1  registered parity result for the last sampled word.
- `out_valid`  out  1  high for exactly one cycle, the cycle after an `in_valid` cycle.
- `err_cnt`  out  CNT_W  saturating count of results with `check`=1 (stats only).
- `err_sticky`  out  1  set on the first `check`=1 result and held (stats only).
- `clr_stats`  in  1  synchronous clear of `err_cnt` and `err_sticky` (stats only).

## Operation
- Raw parity is `p = s[0] ^ s[1] ^ ... ^ s[WIDTH-1]`; the result is `r = p ^ ODD`.
- When `in_valid`=1 at a rising edge: `check <= r` and `out_valid <= 1`.
- When `in_valid`=0: `check` holds its previous value and `out_valid <= 0`.
- For WIDTH=4 and ODD=0, `check`=1 exactly for s ∈ {0001, 0010, 0100, 0111, 1000, 1011, 1101, 1110}.
- Stats update in the same cycle that `out_valid` rises, using the new `check`:
  - If `check`=1, `err_cnt` increments, saturating at 2^CNT_W−1.
  - `err_sticky` sets on the first such result.
- `clr_stats` has priority over a simultaneous increment: the counter goes to 0 and the flag clears. The word being registered in that cycle is not counted.
- X or Z on `s` is not handled.

## Timing
- Latency is one cycle from the `in_valid` sample to `check`/`out_valid`. Throughput is one word per cycle.
- No backpressure; a new word may be presented every cycle.
- Reset (`rst_n`=0 at an edge) sets `check`=0, `out_valid`=0, `err_cnt`=0, `err_sticky`=0.
- Reset has priority over `in_valid` and `clr_stats`.
- A word sampled in the reset cycle is discarded.
- The first valid sample is possible on the first edge with `rst_n`=1.

## Configuration
- `PARITY_CHECK_STATS_EN` defined: `err_cnt`, `err_sticky` and `clr_stats` exist and behave as above.
- Undefined: those three ports and all their logic are absent. `check` and `out_valid` behaviour is unchanged.

## Structure
- Package `parity_check_pkg` holds:
  - the default WIDTH (4) and CNT_W (16) constants;
  - the `ODD_PARITY`/`EVEN_PARITY` parity-sense constants;
  - a typedef for the counter.
- One sub-module, `parity_tree`: a purely combinational, parameterised XOR reduction of WIDTH bits producing `p`.
- The top module adds ODD inversion, the output registers, and the stats.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with s=1111 and `in_valid`=1 → `check`=0, `out_valid`=0, `err_cnt`=0.
- Exhaustive, WIDTH=4, ODD=0: apply s=0000..1111, one per cycle, with `in_valid`=1 → each `check` is one cycle later. s=0000→0, 0001→1, 0011→0, 0111→1, 1111→0. `out_valid` stays high throughout.
- Hold: s=0001 valid, then s=0000 with `in_valid`=0 → `check` stays 1 and `out_valid` drops to 0.
- ODD=1: s=0101 → `check`=1; s=0100 → `check`=0.
- Stats (macro defined): run the 16-word sweep → `err_cnt`=8 and `err_sticky`=1. Assert `clr_stats` together with a valid s=0001 → next cycle `err_cnt`=0 and `err_sticky`=0.
- Saturation, CNT_W=2: five consecutive s=0001 words → `err_cnt` stops at 3.
